hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Producer-side hazard control for the 5-stage RISC-V pipeline.
- Decides when Fetch/Decode must stall and when Decode/Execute must flush. Cases covered: load-use hazards, taken branches/jumps, and results still outstanding from the multi-cycle MUL/DIV unit.
- Keeps a per-register pending scoreboard and an outstanding-operation counter for the MUL/DIV unit.
- Sits beside the forwarding logic. Forwarding resolves the hazards it can; this block stalls or flushes for the ones forwarding cannot.

Parameters:
MD_MAX_OUT, 2, maximum MUL/DIV operations in flight (1..7)
CNT_W, 3, width of outstanding counter; must satisfy 2^CNT_W > MD_MAX_OUT

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
Rs1D  input  5  source register 1 of instruction in Decode
Rs2D  input  5  source register 2 of instruction in Decode
MdD  input  1  instruction in Decode is a MUL/DIV op
RdE  input  5  destination register of instruction in Execute
ResultSrcE0  input  1  instruction in Execute is a load
PCSrcE  input  1  taken branch/jump resolved in Execute
MdIssueE  input  1  MUL/DIV op issues from Execute this cycle
RdMdE  input  5  destination of issuing MUL/DIV op
MdDoneW  input  1  MUL/DIV result written back this cycle
RdMdW  input  5  destination of completing MUL/DIV op
StallF  output  1  hold PC register
StallD  output  1  hold IF/ID register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
MdBusy  output  1  outstanding count nonzero
MdErr  output  1  sticky protocol-violation flag

Behaviour:
- State registers: Pending[31:0], Count[CNT_W-1:0], MdErr. On rst high (async): all cleared.
- While rst is high, all outputs are 0.
- Pending[0] is never set.
- Pending set on a rising clk edge when MdIssueE=1 and RdMdE!=0: set Pending[RdMdE].
- Pending clear on the same edge when MdDoneW=1: clear Pending[RdMdW].
- Set and clear of the same register in the same cycle: set wins, because the new issue is younger.
- Count update per edge:
  - Issue only: +1.
  - Done only: -1.
  - Both issue and done: unchanged.
- Count error cases (set MdErr=1; MdErr clears only on rst):
  - Done with Count=0: Count stays 0.
  - Issue with Count=MD_MAX_OUT: Count saturates.
- MdBusy = (Count!=0), registered-state derived, no input path.
- All stall/flush terms are combinational, same cycle as the inputs.
- lwStall = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- sbStall: for each nonzero RsxD, any of the following stalls:
  - Pending[RsxD]=1 and not (MdDoneW & RdMdW==RsxD). The register file is write-first, so a same-cycle completion releases the stall.
  - MdIssueE & RdMdE==RsxD. This covers an issue in flight before its Pending bit is set.
- mdFull = MdD & (Count + MdIssueE - MdDoneW >= MD_MAX_OUT).
- Stall = lwStall | sbStall | mdFull.
- StallF = StallD = Stall & ~PCSrcE. A taken branch overrides stalls because the Decode instruction is squashed anyway.
- FlushD = PCSrcE.
- FlushE = Stall | PCSrcE. A bubble is inserted behind the stalled instruction.
- Rs1D=Rs2D=pending register: a single stall, no double counting.
- Reset mid-stall: outputs drop to 0 immediately (async); the scoreboard is empty after reset.

Test Plan:
- Load-use: ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0 for that cycle. Same with RdE=0 -> all outputs 0.
- Scoreboard:
  - Issue MUL with RdMdE=7 -> next cycle Pending[7]=1, Count=1, MdBusy=1.
  - Rs2D=7 -> stall each cycle until the MdDoneW=1, RdMdW=7 cycle; in that cycle stall=0, then Count=0.
- Issue-cycle hazard: MdIssueE=1, RdMdE=9, Rs1D=9 in the same cycle -> stall asserted that cycle.
- Structural full, MD_MAX_OUT=2: two issues to x3 and x4 -> Count=2. MdD=1 with unrelated regs -> stall. MdDoneW in the same cycle -> no stall.
- Branch priority: lwStall condition plus PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
- Errors/reset:
  - MdDoneW with Count=0 -> MdErr=1, which stays 1.
  - Assert rst mid-stall -> all outputs 0 asynchronously; Pending=0, Count=0, MdErr=0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
//  Module      : hazard_stall_unit_if
//  Description : Decode/Execute/Writeback hazard signals exchanged between the
//                pipeline datapath (master) and the hazard stall unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic       MdD;
    logic [4:0] RdE;
    logic       ResultSrcE0;
    logic       PCSrcE;
    logic       MdIssueE;
    logic [4:0] RdMdE;
    logic       MdDoneW;
    logic [4:0] RdMdW;
    logic       StallF;
    logic       StallD;
    logic       FlushD;
    logic       FlushE;
    logic       MdBusy;
    logic       MdErr;

    // Pipeline side: drives the pipeline status, consumes stall/flush controls
    modport master (
        output Rs1D, Rs2D, MdD, RdE, ResultSrcE0, PCSrcE,
               MdIssueE, RdMdE, MdDoneW, RdMdW,
        input  StallF, StallD, FlushD, FlushE, MdBusy, MdErr
    );

    // Hazard unit side
    modport slave (
        input  Rs1D, Rs2D, MdD, RdE, ResultSrcE0, PCSrcE,
               MdIssueE, RdMdE, MdDoneW, RdMdW,
        output StallF, StallD, FlushD, FlushE, MdBusy, MdErr
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Stall/flush control for the 5-stage RISC-V pipeline. Covers
//                load-use hazards, taken branches and results still pending
//                in the multi-cycle MUL/DIV unit (per-register scoreboard plus
//                an outstanding-operation counter).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
    parameter int MD_MAX_OUT = 2,
    parameter int CNT_W      = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] c_MD_MAX   = CNT_W'(MD_MAX_OUT);
    localparam logic [CNT_W:0]   c_MD_MAX_X = (CNT_W+1)'(MD_MAX_OUT);

    logic [31:0]      r_pending;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [31:0]      w_pending_nxt;
    logic             w_iss;
    logic             w_done;
    logic             w_lw_stall;
    logic             w_sb1;
    logic             w_sb2;
    logic [CNT_W:0]   w_md_lhs;
    logic [CNT_W:0]   w_md_rhs;
    logic             w_md_full;
    logic             w_stall;

    assign w_iss  = bus.MdIssueE;
    assign w_done = bus.MdDoneW;

    // Next scoreboard: completion clears, issue sets afterwards so a younger issue wins
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_done) begin
            w_pending_nxt[bus.RdMdW] = 1'b0;
        end
        if (w_iss && (bus.RdMdE != 5'd0)) begin
            w_pending_nxt[bus.RdMdE] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Hazard detection: load-use, scoreboard (write-first release) and MUL/DIV capacity
    always_comb begin
        w_lw_stall = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                     ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

        w_sb1 = (bus.Rs1D != 5'd0) &&
                ((r_pending[bus.Rs1D] && !(w_done && (bus.RdMdW == bus.Rs1D))) ||
                 (w_iss && (bus.RdMdE == bus.Rs1D)));
        w_sb2 = (bus.Rs2D != 5'd0) &&
                ((r_pending[bus.Rs2D] && !(w_done && (bus.RdMdW == bus.Rs2D))) ||
                 (w_iss && (bus.RdMdE == bus.Rs2D)));

        // Count + issue - done >= MAX, rearranged to stay unsigned
        w_md_lhs  = {1'b0, r_count} + {{CNT_W{1'b0}}, w_iss};
        w_md_rhs  = c_MD_MAX_X + {{CNT_W{1'b0}}, w_done};
        w_md_full = bus.MdD && (w_md_lhs >= w_md_rhs);

        w_stall = w_lw_stall || w_sb1 || w_sb2 || w_md_full;
    end

    // Scoreboard, outstanding counter and sticky protocol-error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 32'd0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            case ({w_iss, w_done})
                2'b10: begin
                    if (r_count == c_MD_MAX) begin
                        r_err <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (r_count == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    // A taken branch squashes Decode, so it overrides any stall of F/D
    assign bus.StallF = !rst && w_stall && !bus.PCSrcE;
    assign bus.StallD = !rst && w_stall && !bus.PCSrcE;
    assign bus.FlushD = !rst && bus.PCSrcE;
    assign bus.FlushE = !rst && (w_stall || bus.PCSrcE);
    assign bus.MdBusy = !rst && (r_count != '0);
    assign bus.MdErr  = !rst && r_err;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Self-checking bench for hazard_stall_unit. Combinational
//                vectors from a table plus hand-written multi-cycle sequences;
//                expected outputs go through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_stall_unit_if bus ();

    hazard_stall_unit #(
        .MD_MAX_OUT (2),
        .CNT_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mdd;
        logic [4:0] rde;
        logic       ld;
        logic       pcsrc;
        logic       iss;
        logic [4:0] rdmde;
        logic       done;
        logic [4:0] rdmdw;
    } in_t;

    // exp bits: {StallF, StallD, FlushD, FlushE, MdBusy, MdErr}
    typedef struct {
        in_t        in;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t       tbl [9];
    logic [5:0] exp_q [$];
    string      name_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    function automatic in_t mk(input int rs1, input int rs2, input int mdd,
                               input int rde, input int ld, input int pcsrc,
                               input int iss, input int rdmde, input int done,
                               input int rdmdw);
        in_t v;
        v.rs1   = 5'(rs1);
        v.rs2   = 5'(rs2);
        v.mdd   = 1'(mdd);
        v.rde   = 5'(rde);
        v.ld    = 1'(ld);
        v.pcsrc = 1'(pcsrc);
        v.iss   = 1'(iss);
        v.rdmde = 5'(rdmde);
        v.done  = 1'(done);
        v.rdmdw = 5'(rdmdw);
        return v;
    endfunction

    task automatic apply(input in_t v);
        bus.Rs1D        = v.rs1;
        bus.Rs2D        = v.rs2;
        bus.MdD         = v.mdd;
        bus.RdE         = v.rde;
        bus.ResultSrcE0 = v.ld;
        bus.PCSrcE      = v.pcsrc;
        bus.MdIssueE    = v.iss;
        bus.RdMdE       = v.rdmde;
        bus.MdDoneW     = v.done;
        bus.RdMdW       = v.rdmdw;
    endtask

    task automatic push(input logic [5:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic check();
        logic [5:0] act;
        logic [5:0] e;
        string      n;
        act = {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.MdBusy, bus.MdErr};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %b, required an expected entry", act);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got {sF,sD,fD,fE,busy,err}=%b, required %b", n, act, e);
            end
        end
    endtask

    // Drive one cycle just after the edge, compare on the falling edge
    task automatic step(input in_t v, input logic [5:0] e, input string n);
        @(posedge clk);
        #1;
        apply(v);
        push(e, n);
        @(negedge clk);
        check();
    endtask

    task automatic set_vec(input int i, input in_t v, input logic [5:0] e, input string n);
        tbl[i].in   = v;
        tbl[i].exp  = e;
        tbl[i].name = n;
    endtask

    in_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //           rs1 rs2 mdd rde ld pc iss rdmde done rdmdw
        set_vec(0, mk(5,  0,  0,  5,  1, 0, 0,  0,    0,   0), 6'b110100, "lw_rs1");
        set_vec(1, mk(0,  0,  0,  0,  1, 0, 0,  0,    0,   0), 6'b000000, "lw_rd0");
        set_vec(2, mk(0,  12, 0,  12, 1, 0, 0,  0,    0,   0), 6'b110100, "lw_rs2");
        set_vec(3, mk(5,  0,  0,  5,  0, 0, 0,  0,    0,   0), 6'b000000, "not_load");
        set_vec(4, mk(6,  7,  0,  5,  1, 0, 0,  0,    0,   0), 6'b000000, "lw_nomatch");
        set_vec(5, mk(5,  0,  0,  5,  1, 1, 0,  0,    0,   0), 6'b001100, "branch_over_lw");
        set_vec(6, mk(0,  0,  0,  0,  0, 1, 0,  0,    0,   0), 6'b001100, "branch_only");
        set_vec(7, mk(0,  0,  1,  0,  0, 0, 0,  0,    0,   0), 6'b000000, "mdd_empty");
        set_vec(8, mk(5,  5,  0,  5,  1, 0, 0,  0,    0,   0), 6'b110100, "lw_rs1_eq_rs2");

        // Outputs held low during reset even with a hazard presented
        apply(tbl[0].in);
        @(negedge clk);
        push(6'b000000, "in_reset");
        check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].in, tbl[i].exp, tbl[i].name);
        end

        // Scoreboard: MUL to x7, consumer waits until the write-back cycle
        step(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0), 6'b000000, "sb_issue7");
        step(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0), 6'b110110, "sb_wait7_a");
        step(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0), 6'b110110, "sb_wait7_b");
        step(mk(0, 7, 0, 0, 0, 0, 0, 0, 1, 7), 6'b000010, "sb_done7_release");
        step(idle,                              6'b000000, "sb_drained");

        // Same-cycle issue hazard before the pending bit exists
        step(mk(9, 0, 0, 0, 0, 0, 1, 9, 0, 0), 6'b110100, "issue_cycle9");
        step(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b110110, "pending9");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9), 6'b000010, "done9");
        step(idle,                              6'b000000, "drained9");

        // Structural full with MD_MAX_OUT = 2
        step(mk(0,  0, 0, 0, 0, 0, 1, 3, 0, 0), 6'b000000, "full_iss3");
        step(mk(0,  0, 0, 0, 0, 0, 1, 4, 0, 0), 6'b000010, "full_iss4");
        step(mk(10, 0, 1, 0, 0, 0, 0, 0, 0, 0), 6'b110110, "full_stall");
        step(mk(10, 0, 1, 0, 0, 0, 0, 0, 1, 3), 6'b000010, "full_done_frees");
        step(mk(0,  0, 1, 0, 0, 0, 1, 5, 0, 0), 6'b110110, "full_by_issue");
        step(mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 4), 6'b000010, "full_done4");
        step(mk(0,  0, 0, 0, 0, 0, 0, 0, 1, 5), 6'b000010, "full_done5");
        step(idle,                               6'b000000, "full_drained");

        // Underflow sets the sticky error
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 6'b000000, "underflow_cycle");
        step(idle,                              6'b000001, "err_set");
        step(idle,                              6'b000001, "err_sticky");

        // Asynchronous reset in the middle of a scoreboard stall
        step(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0), 6'b000001, "rst_pre_issue7");
        step(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0), 6'b110111, "rst_pre_stall");
        #2;
        rst = 1'b1;
        #1;
        push(6'b000000, "async_rst_outputs");
        check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000, "post_rst_cleared");

        // Issue while already at the limit saturates and flags an error
        step(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0), 6'b000000, "sat_iss3");
        step(mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0), 6'b000010, "sat_iss4");
        step(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0), 6'b000010, "sat_iss5");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3), 6'b000011, "sat_err_done3");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4), 6'b000011, "sat_done4");
        step(idle,                              6'b000001, "sat_count_zero");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
